// File: rtl/step_clock_ctrl.sv
`timescale 1ns/1ps
// Step-clock controller: debounces the lab push-button and issues one-cycle
// ff_en pulses for single-step, counted burst or free-run stepping.
module step_clock_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned RUN_DIV         = 25000000,
   parameter int unsigned BURST_W         = 4
) (
   input  logic               Clock50M,
   input  logic               reset_n,
   input  logic               btn_raw,
   input  logic [1:0]         mode,
   input  logic [BURST_W-1:0] burst_len,
   output logic               ff_en,
   output logic               busy,
   output logic [7:0]         step_count
);

   localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
   localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

   localparam logic [1:0] MODE_STEP  = 2'b00;
   localparam logic [1:0] MODE_BURST = 2'b01;
   localparam logic [1:0] MODE_RUN   = 2'b10;

   typedef enum logic [1:0] {IDLE, BURST, RUN} state_t;

   logic               r_sync1;
   logic               r_sync2;
   logic [DB_W-1:0]    r_db_cnt;
   logic               r_clean;
   logic               r_clean_d;
   logic               r_press;
   state_t             r_state;
   logic [DIV_W-1:0]   r_div;
   logic [BURST_W-1:0] r_remaining;
   logic               r_ff_en;
   logic               r_busy;
   logic [7:0]         r_step_count;

   logic               w_mismatch;
   logic [BURST_W-1:0] w_burst_rem;

   assign w_mismatch  = r_sync2 ^ r_clean;
   assign w_burst_rem = burst_len - BURST_W'(1);

   always_ff @(posedge Clock50M or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_db_cnt  <= '0;
         r_clean   <= 1'b0;
         r_clean_d <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
         if (!w_mismatch) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_MAX) begin
            r_clean  <= r_sync2;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
         end
         r_clean_d <= r_clean;
         r_press   <= r_clean & ~r_clean_d;
      end
   end

   always_ff @(posedge Clock50M or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_div        <= '0;
         r_remaining  <= '0;
         r_ff_en      <= 1'b0;
         r_busy       <= 1'b0;
         r_step_count <= '0;
      end else begin
         r_ff_en <= 1'b0;
         case (r_state)
            IDLE: begin
               r_busy <= 1'b0;
               if (r_press) begin
                  case (mode)
                     MODE_STEP: begin
                        r_ff_en      <= 1'b1;
                        r_step_count <= r_step_count + 8'd1;
                     end
                     MODE_BURST: begin
                        if (burst_len != '0) begin
                           r_ff_en      <= 1'b1;
                           r_step_count <= r_step_count + 8'd1;
                           r_remaining  <= w_burst_rem;
                           r_div        <= '0;
                           if (w_burst_rem != '0) begin
                              r_state <= BURST;
                              r_busy  <= 1'b1;
                           end
                        end
                     end
                     MODE_RUN: begin
                        r_state <= RUN;
                        r_div   <= '0;
                        r_busy  <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            BURST: begin
               if (mode != MODE_BURST) begin
                  r_state <= IDLE;
                  r_div   <= '0;
                  r_busy  <= 1'b0;
               end else if (r_div == DIV_MAX) begin
                  r_ff_en      <= 1'b1;
                  r_step_count <= r_step_count + 8'd1;
                  r_div        <= '0;
                  r_remaining  <= r_remaining - BURST_W'(1);
                  // busy is left high here so it drops the cycle after the last pulse
                  if (r_remaining == BURST_W'(1)) r_state <= IDLE;
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end
            RUN: begin
               if ((mode != MODE_RUN) || r_press) begin
                  r_state <= IDLE;
                  r_div   <= '0;
                  r_busy  <= 1'b0;
               end else if (r_div == DIV_MAX) begin
                  r_ff_en      <= 1'b1;
                  r_step_count <= r_step_count + 8'd1;
                  r_div        <= '0;
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign ff_en      = r_ff_en;
   assign busy       = r_busy;
   assign step_count = r_step_count;

endmodule

// File: tb/tb_step_clock_ctrl.sv
`timescale 1ns/1ps
// Directed bench for step_clock_ctrl: expected ff_en cycles are queued when a
// press is driven and matched against pulses observed on the falling edge.
module tb_step_clock_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       btn_raw = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [3:0] burst_len = 4'd0;
   logic       ff_en;
   logic       busy;
   logic [7:0] step_count;

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         exp_q[$];
   logic [7:0] exp_count = 8'd0;
   logic       prev_en = 1'b0;
   int         t0;
   int         t1;

   step_clock_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .RUN_DIV(3),
      .BURST_W(4)
   ) dut (
      .Clock50M(clk),
      .reset_n(reset_n),
      .btn_raw(btn_raw),
      .mode(mode),
      .burst_len(burst_len),
      .ff_en(ff_en),
      .busy(busy),
      .step_count(step_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic expect_pulse(input int c);
      exp_q.push_back(c);
      exp_count = exp_count + 8'd1;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Pulse monitor: every ff_en must match the oldest queued expected cycle.
   always @(negedge clk) begin
      if (reset_n && ff_en) begin
         check("back_to_back", {31'd0, prev_en}, 32'd0);
         check("pulse_expected", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) check("pulse_cycle", cyc, exp_q.pop_front());
      end
      prev_en = ff_en;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      check("rst_ff_en", {31'd0, ff_en}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_count", {24'd0, step_count}, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: single step
      mode = 2'b00;
      btn_raw = 1'b1; t0 = cyc;
      expect_pulse(t0 + 8);
      wait_cyc(t0 + 8);
      check("s1_busy", {31'd0, busy}, 32'd0);
      wait_cyc(t0 + 20); btn_raw = 1'b0;
      wait_cyc(t0 + 35);
      check("s1_pending", exp_q.size(), 32'd0);
      check("s1_count", {24'd0, step_count}, {24'd0, exp_count});

      // 2: bounce rejection, then a clean hold
      btn_raw = 1'b1; t0 = cyc;
      wait_cyc(t0 + 3); btn_raw = 1'b0;
      wait_cyc(t0 + 5); btn_raw = 1'b1;
      wait_cyc(t0 + 7); btn_raw = 1'b0;
      wait_cyc(t0 + 25);
      check("s2_bounce_count", {24'd0, step_count}, {24'd0, exp_count});
      btn_raw = 1'b1; t0 = cyc;
      expect_pulse(t0 + 8);
      wait_cyc(t0 + 10); btn_raw = 1'b0;
      wait_cyc(t0 + 30);
      check("s2_pending", exp_q.size(), 32'd0);
      check("s2_count", {24'd0, step_count}, {24'd0, exp_count});

      // 3: burst of 4, then burst_len=0
      mode = 2'b01; burst_len = 4'd4;
      btn_raw = 1'b1; t0 = cyc;
      for (int k = 0; k < 4; k++) expect_pulse(t0 + 8 + 3 * k);
      wait_cyc(t0 + 7);
      check("s3_busy_pre", {31'd0, busy}, 32'd0);
      wait_cyc(t0 + 8);
      check("s3_busy_first", {31'd0, busy}, 32'd1);
      wait_cyc(t0 + 10); btn_raw = 1'b0;
      wait_cyc(t0 + 17);
      check("s3_busy_last", {31'd0, busy}, 32'd1);
      wait_cyc(t0 + 18);
      check("s3_busy_after", {31'd0, busy}, 32'd0);
      wait_cyc(t0 + 30);
      check("s3_pending", exp_q.size(), 32'd0);
      check("s3_count", {24'd0, step_count}, {24'd0, exp_count});
      burst_len = 4'd0;
      btn_raw = 1'b1; t0 = cyc;
      wait_cyc(t0 + 10); btn_raw = 1'b0;
      wait_cyc(t0 + 9);
      wait_cyc(t0 + 30);
      check("s3_len0_busy", {31'd0, busy}, 32'd0);
      check("s3_len0_count", {24'd0, step_count}, {24'd0, exp_count});

      // 4: burst abort after the 2nd pulse
      burst_len = 4'd10;
      btn_raw = 1'b1; t0 = cyc;
      expect_pulse(t0 + 8);
      expect_pulse(t0 + 11);
      wait_cyc(t0 + 10); btn_raw = 1'b0;
      wait_cyc(t0 + 11); mode = 2'b11;
      wait_cyc(t0 + 12);
      check("s4_busy_abort", {31'd0, busy}, 32'd0);
      wait_cyc(t0 + 35);
      check("s4_pending", exp_q.size(), 32'd0);
      check("s4_count", {24'd0, step_count}, {24'd0, exp_count});

      // 5: free-run, stopped by a press on a divider=2 cycle
      mode = 2'b10;
      btn_raw = 1'b1; t0 = cyc;
      for (int k = 0; k < 5; k++) expect_pulse(t0 + 11 + 3 * k);
      wait_cyc(t0 + 8);
      check("s5_busy_entry", {31'd0, busy}, 32'd1);
      wait_cyc(t0 + 10); btn_raw = 1'b0;
      wait_cyc(t0 + 18); btn_raw = 1'b1; t1 = cyc;
      wait_cyc(t1 + 7);
      check("s5_busy_run", {31'd0, busy}, 32'd1);
      wait_cyc(t1 + 8);
      check("s5_stop_ff_en", {31'd0, ff_en}, 32'd0);
      check("s5_busy_stop", {31'd0, busy}, 32'd0);
      wait_cyc(t1 + 10); btn_raw = 1'b0;
      wait_cyc(t1 + 30);
      check("s5_pending", exp_q.size(), 32'd0);
      check("s5_count", {24'd0, step_count}, {24'd0, exp_count});

      // 6: wrap, async reset mid-run, button held through reset release
      btn_raw = 1'b1; t0 = cyc;
      for (int k = 0; k < 244; k++) expect_pulse(t0 + 11 + 3 * k);
      wait_cyc(t0 + 10); btn_raw = 1'b0;
      wait_cyc(t0 + 11 + 3 * 241);
      check("s6_count_255", {24'd0, step_count}, 32'd255);
      wait_cyc(t0 + 11 + 3 * 242);
      check("s6_count_wrap", {24'd0, step_count}, 32'd0);
      wait_cyc(t0 + 11 + 3 * 243);
      check("s6_pre_rst_busy", {31'd0, busy}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("s6_rst_ff_en", {31'd0, ff_en}, 32'd0);
      check("s6_rst_busy", {31'd0, busy}, 32'd0);
      check("s6_rst_count", {24'd0, step_count}, 32'd0);
      check("s6_pending", exp_q.size(), 32'd0);
      exp_count = 8'd0;
      btn_raw = 1'b1;
      mode = 2'b00;
      repeat (3) @(negedge clk);
      t0 = cyc;
      expect_pulse(t0 + 8);
      #2 reset_n = 1'b1;
      wait_cyc(t0 + 20); btn_raw = 1'b0;
      wait_cyc(t0 + 40);
      check("s6_held_pending", exp_q.size(), 32'd0);
      check("s6_held_count", {24'd0, step_count}, {24'd0, exp_count});
      check("s6_held_busy", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
